// File: rtl/jfq_disp.sv
// jfq_disp: six-digit multiplexed 7-segment driver for the billing front panel.
//   Snapshots the BCD balance (outmoney, shown as XX.X on digits 5..3) and the
//   BCD call minutes (outtime, digits 2..0) while write is high, then scans
//   them onto a common-cathode display. warn blinks the money digits, cut shows
//   dashes on every digit.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   outmoney[10:0]    BCD balance {hundreds(3b), tens, units}, 0.1-yuan units
//   outtime[8:0]      BCD minutes {hundreds(1b), tens, units}
//   write, warn, cut  snapshot strobe, low-balance blink, cut-off dashes
//   seg[6:0], dp      segments {g,f,e,d,c,b,a} and decimal point, active-high
//   an[5:0]           digit enables, active-low one-hot, an[5] leftmost
//   bcd_err           sticky: an invalid BCD nibble was captured
module jfq_disp #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] outmoney,
  input  logic [8:0]  outtime,
  input  logic        write,
  input  logic        warn,
  input  logic        cut,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        bcd_err
);

  localparam logic [7:0] SCAN_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  logic [10:0] money_q, money_d;
  logic [8:0]  time_q, time_d;
  logic [7:0]  presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  frm_q, frm_d;
  logic        phase_q, phase_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [5:0]  an_q, an_d;
  logic        bcd_err_q, bcd_err_d;

  logic        presc_wrap, frame_tick, blink_off;
  logic [3:0]  nib;
  logic        zero_blank, money_dig;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h79;  // invalid BCD shows 'E'
    endcase
  endfunction

  // Snapshot registers and sticky BCD error
  always_comb begin
    money_d   = money_q;
    time_d    = time_q;
    bcd_err_d = bcd_err_q;
    if (write) begin
      money_d = outmoney;
      time_d  = outtime;
      if ((outmoney[7:4] > 4'd9) || (outmoney[3:0] > 4'd9) ||
          (outtime[7:4] > 4'd9) || (outtime[3:0] > 4'd9)) begin
        bcd_err_d = 1'b1;
      end
    end
  end

  // Scan prescaler, digit index and blink frame counter
  always_comb begin
    presc_wrap = (presc_q == SCAN_LAST);
    frame_tick = presc_wrap && (idx_q == 3'd5);
    presc_d    = presc_wrap ? 8'd0 : presc_q + 8'd1;
    idx_d      = idx_q;
    if (presc_wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!warn) begin
      frm_d   = 8'd0;
      phase_d = 1'b0;
    end else if (frame_tick) begin
      if (frm_q == BLINK_LAST) begin
        frm_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 8'd1;
      end
    end
  end

  // Digit select with leading-zero blanking; the money tens digit carries dp
  always_comb begin
    nib        = time_q[3:0];
    zero_blank = 1'b0;
    money_dig  = 1'b0;
    case (idx_q)
      3'd0: nib = time_q[3:0];
      3'd1: begin
        nib        = time_q[7:4];
        zero_blank = !time_q[8] && (time_q[7:4] == 4'd0);
      end
      3'd2: begin
        nib        = {3'b000, time_q[8]};
        zero_blank = !time_q[8];
      end
      3'd3: begin
        nib       = money_q[3:0];
        money_dig = 1'b1;
      end
      3'd4: begin
        nib       = money_q[7:4];
        money_dig = 1'b1;
      end
      3'd5: begin
        nib        = {1'b0, money_q[10:8]};
        zero_blank = (money_q[10:8] == 3'd0);
        money_dig  = 1'b1;
      end
      default: ;
    endcase
  end

  // Output priority: cut > blink > leading-zero blank > digit value
  always_comb begin
    blink_off = warn && phase_q && money_dig;
    an_d      = ~(6'b000001 << idx_q);
    dp_d      = (idx_q == 3'd4) && !cut && !blink_off;
    if (cut)             seg_d = 7'h40;
    else if (blink_off)  seg_d = 7'h00;
    else if (zero_blank) seg_d = 7'h00;
    else                 seg_d = seg7(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      money_q   <= 11'h500;
      time_q    <= 9'h000;
      bcd_err_q <= 1'b0;
      presc_q   <= 8'd0;
      idx_q     <= 3'd0;
      frm_q     <= 8'd0;
      phase_q   <= 1'b0;
      seg_q     <= 7'h00;
      dp_q      <= 1'b0;
      an_q      <= 6'b111111;
    end else begin
      money_q   <= money_d;
      time_q    <= time_d;
      bcd_err_q <= bcd_err_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      frm_q     <= frm_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_jfq_disp.sv
// Testbench for jfq_disp with SCAN_DIV=4, BLINK_DIV=2.
module tb_jfq_disp;

  localparam int SD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] outmoney = '0;
  logic [8:0]  outtime = '0;
  logic        write = 1'b0;
  logic        warn = 1'b0;
  logic        cut = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        bcd_err;

  int n_cmp = 0;
  int n_bad = 0;

  jfq_disp #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .outmoney(outmoney), .outtime(outtime),
    .write(write), .warn(warn), .cut(cut),
    .seg(seg), .dp(dp), .an(an), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // Reference model: cycle count since reset decides which digit is lit,
  // completed frames while warn is held decide the blink phase.
  function automatic logic [6:0] font(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v > 9) return 7'h79;
    return tbl[v];
  endfunction

  int unsigned t_m, ticks_m;
  logic [10:0] money_m;
  logic [8:0]  time_m;
  logic        err_m;
  logic [5:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or negedge rst_n) begin
    int d, v;
    bit blankz, blink;
    if (!rst_n) begin
      t_m = 0; ticks_m = 0; money_m = 11'h500; time_m = 9'h000; err_m = 1'b0;
      exp_an = 6'b111111; exp_seg = 7'h00; exp_dp = 1'b0;
    end else begin
      d = (t_m % (6 * SD)) / SD;
      blankz = 1'b0;
      if (d < 3) begin
        v = (d == 0) ? int'(time_m[3:0]) : (d == 1) ? int'(time_m[7:4]) : int'(time_m[8]);
        if (d == 2) blankz = (time_m[8] == 1'b0);
        if (d == 1) blankz = (time_m[8] == 1'b0) && (time_m[7:4] == 4'd0);
      end else begin
        v = (d == 3) ? int'(money_m[3:0]) : (d == 4) ? int'(money_m[7:4]) : int'(money_m[10:8]);
        if (d == 5) blankz = (v == 0);
      end
      blink = warn && (((ticks_m / BD) % 2) == 1);
      exp_an = 6'b111111;
      exp_an[d] = 1'b0;
      if (cut) begin
        exp_seg = 7'h40; exp_dp = 1'b0;
      end else if (blink && d >= 3) begin
        exp_seg = 7'h00; exp_dp = 1'b0;
      end else begin
        exp_seg = blankz ? 7'h00 : font(v);
        exp_dp  = (d == 4);
      end
      if (write) begin
        money_m = outmoney;
        time_m  = outtime;
        if (outmoney[7:4] > 9 || outmoney[3:0] > 9 || outtime[7:4] > 9 || outtime[3:0] > 9)
          err_m = 1'b1;
      end
      if (!warn) ticks_m = 0;
      else if ((t_m % (6 * SD)) == 6 * SD - 1) ticks_m++;
      t_m++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, bcd_err} !== {6'b111111, 7'h00, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset: got an=%b seg=%h dp=%b err=%b, expected an=111111 seg=00 dp=0 err=0",
                 an, seg, dp, bcd_err);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic run_cmp(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, bcd_err} !== {exp_an, exp_seg, exp_dp, err_m}) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got an=%b seg=%h dp=%b err=%b, expected an=%b seg=%h dp=%b err=%b",
                 name, i, an, seg, dp, bcd_err, exp_an, exp_seg, exp_dp, err_m);
      end
    end
  endtask

  task automatic test_idle_scan();
    run_cmp("idle_scan", 60);
  endtask

  task automatic test_load();
    outmoney = 11'h497; outtime = 9'h112; write = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, bcd_err} !== {exp_an, exp_seg, exp_dp, err_m}) begin
      n_bad++;
      $display("FAIL load_strobe: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               an, seg, dp, exp_an, exp_seg, exp_dp);
    end
    write = 1'b0;
    outmoney = 11'h000; outtime = 9'h000;
    run_cmp("load_hold", 60);
  endtask

  task automatic test_warn_blink();
    warn = 1'b1;
    run_cmp("warn_blink", 220);
    warn = 1'b0;
    run_cmp("warn_drop", 30);
  endtask

  task automatic test_cut();
    warn = 1'b1;
    run_cmp("warn_pre_cut", 30);
    cut = 1'b1;
    run_cmp("cut", 60);
    cut = 1'b0;
    run_cmp("cut_release", 120);
    warn = 1'b0;
  endtask

  task automatic test_bcd_err();
    outmoney = 11'h0A3; outtime = 9'h007; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    run_cmp("bcd_err_load", 30);
    n_cmp++;
    if (bcd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bcd_err_set: got %b, expected 1", bcd_err);
    end
    outmoney = 11'h234; outtime = 9'h045; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    run_cmp("bcd_err_sticky", 30);
    n_cmp++;
    if (bcd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL bcd_err_sticky: got %b, expected 1", bcd_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, bcd_err} !== {exp_an, exp_seg, exp_dp, err_m}) begin
        n_bad++;
        $display("FAIL random cyc %0d: got an=%b seg=%h dp=%b err=%b, expected an=%b seg=%h dp=%b err=%b",
                 i, an, seg, dp, bcd_err, exp_an, exp_seg, exp_dp, err_m);
      end
      write    = ($urandom_range(0, 9) == 0);
      outmoney = 11'($urandom);
      outtime  = 9'($urandom);
      if ($urandom_range(0, 59) == 0) warn = ~warn;
      if ($urandom_range(0, 39) == 0) cut = ~cut;
    end
    write = 1'b0; warn = 1'b0; cut = 1'b0;
  endtask

  task automatic test_reset_mid();
    outmoney = 11'h123; outtime = 9'h045; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    run_cmp("pre_reset", 17);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, dp, bcd_err} !== {6'b111111, 7'h00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got an=%b seg=%h dp=%b err=%b, expected an=111111 seg=00 dp=0 err=0",
               an, seg, dp, bcd_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp("post_reset", 30);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load();
    test_warn_blink();
    test_cut();
    test_bcd_err();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
